// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 encodings for the execute stage.
//   - icode and status constants
//   - "no register" ID
//   - ALU function codes
//   - condition ifun codes
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IcHalt  = 4'h0;
    localparam logic [3:0] IcNop   = 4'h1;
    localparam logic [3:0] IcCmov  = 4'h2;
    localparam logic [3:0] IcIrmov = 4'h3;
    localparam logic [3:0] IcRmmov = 4'h4;
    localparam logic [3:0] IcMrmov = 4'h5;
    localparam logic [3:0] IcOp    = 4'h6;
    localparam logic [3:0] IcJ     = 4'h7;
    localparam logic [3:0] IcCall  = 4'h8;
    localparam logic [3:0] IcRet   = 4'h9;
    localparam logic [3:0] IcPush  = 4'hA;
    localparam logic [3:0] IcPop   = 4'hB;

    // Status codes
    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatHlt = 3'd2;
    localparam logic [2:0] StatAdr = 3'd3;
    localparam logic [2:0] StatIns = 3'd4;

    localparam logic [3:0] RegNone = 4'hF;

    // ALU function codes (OPq ifun)
    localparam logic [3:0] AluAdd = 4'd0;
    localparam logic [3:0] AluSub = 4'd1;
    localparam logic [3:0] AluAnd = 4'd2;
    localparam logic [3:0] AluXor = 4'd3;

    // Condition codes (jXX / cmovXX ifun)
    localparam logic [3:0] CondAlways = 4'd0;
    localparam logic [3:0] CondLe     = 4'd1;
    localparam logic [3:0] CondL      = 4'd2;
    localparam logic [3:0] CondE      = 4'd3;
    localparam logic [3:0] CondNe     = 4'd4;
    localparam logic [3:0] CondGe     = 4'd5;
    localparam logic [3:0] CondG      = 4'd6;

endpackage

// File: rtl/y86_alu.sv
// y86_alu: combinational Y86-64 ALU.
//   a_i, b_i  : operands (sub computes b_i - a_i)
//   fun_i     : AluAdd / AluSub / AluAnd / AluXor; anything else gives 0
//   result_o  : result, wraps mod 2^W
//   zf_o, sf_o, of_o : zero, sign, signed-overflow flags of result_o
module y86_alu
    import y86_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [3:0]   fun_i,
    output logic [W-1:0] result_o,
    output logic         zf_o,
    output logic         sf_o,
    output logic         of_o
);

    always_comb begin
        result_o = '0;
        of_o     = 1'b0;
        case (fun_i)
            AluAdd: begin
                result_o = b_i + a_i;
                of_o     = (a_i[W-1] == b_i[W-1]) && (result_o[W-1] != a_i[W-1]);
            end
            AluSub: begin
                result_o = b_i - a_i;
                of_o     = (a_i[W-1] != b_i[W-1]) && (result_o[W-1] != b_i[W-1]);
            end
            AluAnd:  result_o = a_i & b_i;
            AluXor:  result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
    end

    assign zf_o = (result_o == '0);
    assign sf_o = result_o[W-1];

endmodule

// File: rtl/execute_stage.sv
// execute_stage: Y86-64 pipeline execute stage.
//   Inputs : clk, rst_n (async, active-low), E_bubble / M_bubble,
//            d_* decode outputs, m_stat / W_stat downstream status.
//   Outputs: e_dstE / e_Value_E forwarding pair (comb.), e_Cnd (comb.),
//            M_* memory-stage pipeline register, cc = {ZF,SF,OF}.
// Holds the E register, the condition-code register and the M register.
module execute_stage
    import y86_pkg::*;
#(
    parameter int unsigned W     = 64,
    parameter logic [3:0]  RNONE = 4'd15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         E_bubble,
    input  logic         M_bubble,
    input  logic [2:0]   d_stat,
    input  logic [3:0]   d_icode,
    input  logic [3:0]   d_ifun,
    input  logic [W-1:0] d_Val_C,
    input  logic [W-1:0] d_value_A,
    input  logic [W-1:0] d_value_B,
    input  logic [3:0]   d_dstE,
    input  logic [3:0]   d_dstM,
    input  logic [2:0]   m_stat,
    input  logic [2:0]   W_stat,
    output logic [3:0]   e_dstE,
    output logic [W-1:0] e_Value_E,
    output logic         e_Cnd,
    output logic [2:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic         M_Cnd,
    output logic [W-1:0] M_Value_E,
    output logic [W-1:0] M_Value_A,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM,
    output logic [2:0]   cc
);

    // E pipeline register
    logic [2:0]   ex_stat_q,  ex_stat_d;
    logic [3:0]   ex_icode_q, ex_icode_d;
    logic [3:0]   ex_ifun_q,  ex_ifun_d;
    logic [W-1:0] ex_val_c_q, ex_val_c_d;
    logic [W-1:0] ex_val_a_q, ex_val_a_d;
    logic [W-1:0] ex_val_b_q, ex_val_b_d;
    logic [3:0]   ex_dst_e_q, ex_dst_e_d;
    logic [3:0]   ex_dst_m_q, ex_dst_m_d;

    // M pipeline register
    logic [2:0]   mem_stat_q,  mem_stat_d;
    logic [3:0]   mem_icode_q, mem_icode_d;
    logic         mem_cnd_q,   mem_cnd_d;
    logic [W-1:0] mem_val_e_q, mem_val_e_d;
    logic [W-1:0] mem_val_a_q, mem_val_a_d;
    logic [3:0]   mem_dst_e_q, mem_dst_e_d;
    logic [3:0]   mem_dst_m_q, mem_dst_m_d;

    // Condition codes {ZF,SF,OF}
    logic [2:0] cc_q, cc_d;

    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_fun;
    logic         alu_zf, alu_sf, alu_of;
    logic         cond, lt, set_cc;

    always_comb begin
        if (E_bubble) begin
            ex_stat_d  = StatAok;
            ex_icode_d = IcNop;
            ex_ifun_d  = 4'd0;
            ex_val_c_d = '0;
            ex_val_a_d = '0;
            ex_val_b_d = '0;
            ex_dst_e_d = RNONE;
            ex_dst_m_d = RNONE;
        end else begin
            ex_stat_d  = d_stat;
            ex_icode_d = d_icode;
            ex_ifun_d  = d_ifun;
            ex_val_c_d = d_Val_C;
            ex_val_a_d = d_value_A;
            ex_val_b_d = d_value_B;
            ex_dst_e_d = d_dstE;
            ex_dst_m_d = d_dstM;
        end
    end

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (ex_icode_q)
            IcCmov, IcOp:             alu_a = ex_val_a_q;
            IcIrmov, IcRmmov, IcMrmov: alu_a = ex_val_c_q;
            IcCall, IcPush:           alu_a = ~W'(7);  // -8
            IcRet, IcPop:             alu_a = W'(8);
            default:                  alu_a = '0;
        endcase
        case (ex_icode_q)
            IcRmmov, IcMrmov, IcOp, IcCall, IcRet, IcPush, IcPop: alu_b = ex_val_b_q;
            default: alu_b = '0;
        endcase
    end

    assign alu_fun = (ex_icode_q == IcOp) ? ex_ifun_q : AluAdd;

    y86_alu #(
        .W (W)
    ) u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .fun_i    (alu_fun),
        .result_o (alu_result),
        .zf_o     (alu_zf),
        .sf_o     (alu_sf),
        .of_o     (alu_of)
    );

    // Condition evaluated on the current cc, i.e. before this instruction's own update.
    assign lt = cc_q[1] ^ cc_q[0];

    always_comb begin
        cond = 1'b0;
        case (ex_ifun_q)
            CondAlways: cond = 1'b1;
            CondLe:     cond = lt | cc_q[2];
            CondL:      cond = lt;
            CondE:      cond = cc_q[2];
            CondNe:     cond = ~cc_q[2];
            CondGe:     cond = ~lt;
            CondG:      cond = ~lt & ~cc_q[2];
            default:    cond = 1'b0;
        endcase
    end

    assign e_Cnd     = ((ex_icode_q == IcCmov) || (ex_icode_q == IcJ)) ? cond : 1'b0;
    assign e_Value_E = alu_result;
    assign e_dstE    = ((ex_icode_q == IcCmov) && !e_Cnd) ? RNONE : ex_dst_e_q;

    // Only a cleanly executing OPq may touch cc; faulting older instructions block it.
    assign set_cc = (ex_icode_q == IcOp) && (m_stat == StatAok) && (W_stat == StatAok) &&
                    (ex_stat_q == StatAok);
    assign cc_d   = set_cc ? {alu_zf, alu_sf, alu_of} : cc_q;

    always_comb begin
        if (M_bubble) begin
            mem_stat_d  = StatAok;
            mem_icode_d = IcNop;
            mem_cnd_d   = 1'b0;
            mem_val_e_d = '0;
            mem_val_a_d = '0;
            mem_dst_e_d = RNONE;
            mem_dst_m_d = RNONE;
        end else begin
            mem_stat_d  = ex_stat_q;
            mem_icode_d = ex_icode_q;
            mem_cnd_d   = e_Cnd;
            mem_val_e_d = alu_result;
            mem_val_a_d = ex_val_a_q;
            mem_dst_e_d = e_dstE;
            mem_dst_m_d = ex_dst_m_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_stat_q   <= StatAok;
            ex_icode_q  <= IcNop;
            ex_ifun_q   <= 4'd0;
            ex_val_c_q  <= '0;
            ex_val_a_q  <= '0;
            ex_val_b_q  <= '0;
            ex_dst_e_q  <= RNONE;
            ex_dst_m_q  <= RNONE;
            mem_stat_q  <= StatAok;
            mem_icode_q <= IcNop;
            mem_cnd_q   <= 1'b0;
            mem_val_e_q <= '0;
            mem_val_a_q <= '0;
            mem_dst_e_q <= RNONE;
            mem_dst_m_q <= RNONE;
            cc_q        <= 3'b100;
        end else begin
            ex_stat_q   <= ex_stat_d;
            ex_icode_q  <= ex_icode_d;
            ex_ifun_q   <= ex_ifun_d;
            ex_val_c_q  <= ex_val_c_d;
            ex_val_a_q  <= ex_val_a_d;
            ex_val_b_q  <= ex_val_b_d;
            ex_dst_e_q  <= ex_dst_e_d;
            ex_dst_m_q  <= ex_dst_m_d;
            mem_stat_q  <= mem_stat_d;
            mem_icode_q <= mem_icode_d;
            mem_cnd_q   <= mem_cnd_d;
            mem_val_e_q <= mem_val_e_d;
            mem_val_a_q <= mem_val_a_d;
            mem_dst_e_q <= mem_dst_e_d;
            mem_dst_m_q <= mem_dst_m_d;
            cc_q        <= cc_d;
        end
    end

    assign M_stat    = mem_stat_q;
    assign M_icode   = mem_icode_q;
    assign M_Cnd     = mem_cnd_q;
    assign M_Value_E = mem_val_e_q;
    assign M_Value_A = mem_val_a_q;
    assign M_dstE    = mem_dst_e_q;
    assign M_dstM    = mem_dst_m_q;
    assign cc        = cc_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed literal checks plus randomized stimulus against a
// behavioural model of the execute stage.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        E_bubble, M_bubble;
    logic [2:0]  d_stat;
    logic [3:0]  d_icode, d_ifun, d_dstE, d_dstM;
    logic [63:0] d_Val_C, d_value_A, d_value_B;
    logic [2:0]  m_stat, W_stat;
    logic [3:0]  e_dstE;
    logic [63:0] e_Value_E;
    logic        e_Cnd;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_Value_E, M_Value_A;
    logic [3:0]  M_dstE, M_dstM;
    logic [2:0]  cc;

    int n_checks = 0;
    int n_fail   = 0;

    execute_stage #(
        .W     (64),
        .RNONE (4'd15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .E_bubble  (E_bubble),
        .M_bubble  (M_bubble),
        .d_stat    (d_stat),
        .d_icode   (d_icode),
        .d_ifun    (d_ifun),
        .d_Val_C   (d_Val_C),
        .d_value_A (d_value_A),
        .d_value_B (d_value_B),
        .d_dstE    (d_dstE),
        .d_dstM    (d_dstM),
        .m_stat    (m_stat),
        .W_stat    (W_stat),
        .e_dstE    (e_dstE),
        .e_Value_E (e_Value_E),
        .e_Cnd     (e_Cnd),
        .M_stat    (M_stat),
        .M_icode   (M_icode),
        .M_Cnd     (M_Cnd),
        .M_Value_E (M_Value_E),
        .M_Value_A (M_Value_A),
        .M_dstE    (M_dstE),
        .M_dstM    (M_dstM),
        .cc        (cc)
    );

    always #5 clk = ~clk;

    // Model state: the instruction sitting in E, the contents of M, and cc.
    logic [2:0]  me_stat;
    logic [3:0]  me_icode, me_ifun, me_dste, me_dstm;
    logic [63:0] me_valc, me_vala, me_valb;
    logic [2:0]  mm_stat;
    logic [3:0]  mm_icode, mm_dste, mm_dstm;
    logic        mm_cnd;
    logic [63:0] mm_vale, mm_vala;
    logic [2:0]  mcc;

    typedef struct packed {
        logic [63:0] val;
        logic        zf;
        logic        sf;
        logic        of;
    } alu_t;

    // Result and flags from the instruction semantics; overflow via 65-bit signed arithmetic.
    function automatic alu_t f_exec(input logic [3:0] ic, input logic [3:0] ifn,
                                    input logic [63:0] vc, input logic [63:0] va,
                                    input logic [63:0] vb);
        alu_t        r;
        logic [63:0] a, b;
        logic [64:0] wide;
        case (ic)
            4'd2, 4'd6:       a = va;
            4'd3, 4'd4, 4'd5: a = vc;
            4'd8, 4'd10:      a = 64'hFFFF_FFFF_FFFF_FFF8;
            4'd9, 4'd11:      a = 64'd8;
            default:          a = 64'd0;
        endcase
        b = (ic inside {4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11}) ? vb : 64'd0;
        r.of = 1'b0;
        if (ic == 4'd6 && ifn == 4'd1) begin
            wide  = {b[63], b} - {a[63], a};
            r.val = wide[63:0];
            r.of  = wide[64] ^ wide[63];
        end else if (ic == 4'd6 && ifn == 4'd2) begin
            r.val = a & b;
        end else if (ic == 4'd6 && ifn == 4'd3) begin
            r.val = a ^ b;
        end else if (ic == 4'd6 && ifn != 4'd0) begin
            r.val = 64'd0;
        end else begin
            wide  = {a[63], a} + {b[63], b};
            r.val = wide[63:0];
            r.of  = wide[64] ^ wide[63];
        end
        r.zf = (r.val == 64'd0);
        r.sf = r.val[63];
        return r;
    endfunction

    function automatic logic f_cond(input logic [3:0] ifn, input logic [2:0] c);
        logic zf, less;
        zf   = c[2];
        less = c[1] ^ c[0];
        case (ifn)
            4'd0:    return 1'b1;
            4'd1:    return less || zf;
            4'd2:    return less;
            4'd3:    return zf;
            4'd4:    return !zf;
            4'd5:    return !less;
            4'd6:    return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic f_cnd(input logic [3:0] ic, input logic [3:0] ifn,
                                   input logic [2:0] c);
        return (ic == 4'd2 || ic == 4'd7) ? f_cond(ifn, c) : 1'b0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        me_stat = 3'd1; me_icode = 4'd1; me_ifun = 4'd0;
        me_valc = '0;   me_vala = '0;    me_valb = '0;
        me_dste = 4'hF; me_dstm = 4'hF;
        mm_stat = 3'd1; mm_icode = 4'd1; mm_cnd = 1'b0;
        mm_vale = '0;   mm_vala = '0;    mm_dste = 4'hF; mm_dstm = 4'hF;
        mcc     = 3'b100;
    endtask

    task automatic check_all();
        alu_t        r;
        logic        c;
        logic [3:0]  de;
        r  = f_exec(me_icode, me_ifun, me_valc, me_vala, me_valb);
        c  = f_cnd(me_icode, me_ifun, mcc);
        de = (me_icode == 4'd2 && !c) ? 4'hF : me_dste;
        chk("e_Value_E", e_Value_E, r.val);
        chk("e_Cnd", 64'(e_Cnd), 64'(c));
        chk("e_dstE", 64'(e_dstE), 64'(de));
        chk("M_stat", 64'(M_stat), 64'(mm_stat));
        chk("M_icode", 64'(M_icode), 64'(mm_icode));
        chk("M_Cnd", 64'(M_Cnd), 64'(mm_cnd));
        chk("M_Value_E", M_Value_E, mm_vale);
        chk("M_Value_A", M_Value_A, mm_vala);
        chk("M_dstE", 64'(M_dstE), 64'(mm_dste));
        chk("M_dstM", 64'(M_dstM), 64'(mm_dstm));
        chk("cc", 64'(cc), 64'(mcc));
    endtask

    // One clock: compute what this edge must do, let it happen, then compare.
    task automatic cycle();
        alu_t       r;
        logic       c, set_cc;
        logic [3:0] de;
        r      = f_exec(me_icode, me_ifun, me_valc, me_vala, me_valb);
        c      = f_cnd(me_icode, me_ifun, mcc);
        de     = (me_icode == 4'd2 && !c) ? 4'hF : me_dste;
        set_cc = me_icode == 4'd6 && m_stat == 3'd1 && W_stat == 3'd1 && me_stat == 3'd1;
        @(posedge clk);
        if (M_bubble) begin
            mm_stat = 3'd1; mm_icode = 4'd1; mm_cnd = 1'b0; mm_vale = '0; mm_vala = '0;
            mm_dste = 4'hF; mm_dstm = 4'hF;
        end else begin
            mm_stat = me_stat; mm_icode = me_icode; mm_cnd = c; mm_vale = r.val;
            mm_vala = me_vala; mm_dste = de; mm_dstm = me_dstm;
        end
        if (set_cc) mcc = {r.zf, r.sf, r.of};
        if (E_bubble) begin
            me_stat = 3'd1; me_icode = 4'd1; me_ifun = 4'd0; me_valc = '0; me_vala = '0;
            me_valb = '0; me_dste = 4'hF; me_dstm = 4'hF;
        end else begin
            me_stat = d_stat; me_icode = d_icode; me_ifun = d_ifun; me_valc = d_Val_C;
            me_vala = d_value_A; me_valb = d_value_B; me_dste = d_dstE; me_dstm = d_dstM;
        end
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst M_icode", 64'(M_icode), 64'd1);
        chk("rst M_dstE", 64'(M_dstE), 64'd15);
        chk("rst M_dstM", 64'(M_dstM), 64'd15);
        chk("rst M_stat", 64'(M_stat), 64'd1);
        chk("rst cc", 64'(cc), 64'b100);
        check_all();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic set_d(input logic [3:0] ic, input logic [3:0] ifn, input logic [63:0] vc,
                         input logic [63:0] va, input logic [63:0] vb, input logic [3:0] de);
        d_stat = 3'd1; d_icode = ic; d_ifun = ifn; d_Val_C = vc;
        d_value_A = va; d_value_B = vb; d_dstE = de; d_dstM = 4'hF;
    endtask

    function automatic logic [63:0] rand_val();
        case ($urandom_range(0, 4))
            0:       return 64'($urandom_range(0, 300));
            1:       return 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 2));
            2:       return 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 2));
            3:       return 64'd0 - 64'($urandom_range(1, 300));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; E_bubble = 1'b0; M_bubble = 1'b0;
        m_stat = 3'd1; W_stat = 3'd1;
        set_d(4'd1, 4'd0, '0, '0, '0, 4'hF);
        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        reset_pulse();

        // sub: 3 - 5 = -2, flags {0,1,0}
        set_d(4'd6, 4'd1, '0, 64'd5, 64'd3, 4'd2);
        cycle();
        chk("sub e_Value_E", e_Value_E, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub e_dstE", 64'(e_dstE), 64'd2);
        set_d(4'd2, 4'd1, '0, 64'd7, '0, 4'd3);  // cmovle
        cycle();
        chk("sub M_Value_E", M_Value_E, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub cc", 64'(cc), 64'b010);
        chk("cmovle e_Cnd", 64'(e_Cnd), 64'd1);
        chk("cmovle e_dstE", 64'(e_dstE), 64'd3);
        set_d(4'd2, 4'd6, '0, 64'd7, '0, 4'd3);  // cmovg
        cycle();
        chk("cmovg e_Cnd", 64'(e_Cnd), 64'd0);
        chk("cmovg e_dstE", 64'(e_dstE), 64'd15);
        set_d(4'd6, 4'd0, '0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd4);
        cycle();
        chk("cmovg M_dstE", 64'(M_dstE), 64'd15);
        chk("add e_Value_E", e_Value_E, 64'h8000_0000_0000_0000);
        set_d(4'd7, 4'd2, 64'h40, '0, '0, 4'hF);  // jl
        cycle();
        chk("add cc", 64'(cc), 64'b011);
        chk("jl e_Cnd", 64'(e_Cnd), 64'd0);
        set_d(4'd7, 4'd1, 64'h40, '0, '0, 4'hF);  // jle
        cycle();
        chk("jle e_Cnd", 64'(e_Cnd), 64'd0);
        set_d(4'hA, 4'd0, '0, 64'h1234, 64'd256, 4'd4);
        cycle();
        chk("pushq e_Value_E", e_Value_E, 64'd248);
        set_d(4'hB, 4'd0, '0, 64'd256, 64'd256, 4'd4);
        cycle();
        chk("popq e_Value_E", e_Value_E, 64'd264);
        set_d(4'd8, 4'd0, 64'h80, 64'hABCD, 64'd256, 4'd4);
        cycle();
        chk("call e_Value_E", e_Value_E, 64'd248);
        set_d(4'd1, 4'd0, '0, '0, '0, 4'hF);
        cycle();
        chk("call M_Value_A", M_Value_A, 64'hABCD);

        // Suppression: xor 5^5 would give cc {1,0,0}
        set_d(4'd6, 4'd3, '0, 64'd5, 64'd5, 4'd1);
        cycle();
        m_stat = 3'd3;
        cycle();
        chk("m_stat ADR cc", 64'(cc), 64'b011);
        m_stat = 3'd1; W_stat = 3'd2; E_bubble = 1'b1;
        cycle();
        chk("W_stat HLT cc", 64'(cc), 64'b011);
        chk("xor M_icode", 64'(M_icode), 64'd6);
        W_stat = 3'd1; E_bubble = 1'b0;
        set_d(4'd1, 4'd0, '0, '0, '0, 4'hF);
        cycle();
        chk("bubble M_icode", 64'(M_icode), 64'd1);
        chk("bubble cc", 64'(cc), 64'b011);

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            d_stat    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            d_icode   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) :
                        (($urandom_range(0, 2) == 0) ? 4'd2 :
                         (($urandom_range(0, 1) == 0) ? 4'd7 : 4'd6));
            d_ifun    = 4'($urandom_range(0, 7));
            d_Val_C   = rand_val();
            d_value_A = rand_val();
            d_value_B = rand_val();
            d_dstE    = 4'($urandom_range(0, 15));
            d_dstM    = 4'($urandom_range(0, 15));
            m_stat    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            W_stat    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            E_bubble  = ($urandom_range(0, 9) == 0);
            M_bubble  = ($urandom_range(0, 9) == 0);
            if (i == 300) reset_pulse();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Y86-64 pipeline execute stage. Holds the E pipeline register loaded from decode outputs, and computes the ALU result and the branch/cmov condition. Owns the condition-code register. Registers results into the M pipeline register for the memory stage. Drives the combinational `e_dstE` / `e_Value_E` forwarding pair back into decode.

## Interface
Parameters:
- `W`, 64: datapath width.
- `RNONE`, 4'd15: "no register" ID.

Ports:
- `clk`  in  1: clock, all state updates on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `E_bubble`  in  1: load a bubble into E instead of decode outputs.
- `M_bubble`  in  1: load a bubble into M instead of execute results.
- `d_stat`  in  3: decode status.
- `d_icode`, `d_ifun`  in  4 each: instruction code and function.
- `d_Val_C`, `d_value_A`, `d_value_B`  in  W each: constant and forwarded operands.
- `d_dstE`, `d_dstM`  in  4 each: destination IDs.
- `m_stat`, `W_stat`  in  3 each: downstream statuses, used to gate the CC update.
- `e_dstE`  out  4: forwarded destE (comb.); RNONE for a cmov that is not taken.
- `e_Value_E`  out  W: ALU result (comb.).
- `e_Cnd`  out  1: condition result (comb.), used by pipeline control.
- `M_stat` 3, `M_icode` 4, `M_Cnd` 1, `M_Value_E` W, `M_Value_A` W, `M_dstE` 4, `M_dstM` 4: out, M register contents.
- `cc`  out  3: {ZF,SF,OF}.

## Operation
- Status codes:
  - AOK=1, HLT=2, ADR=3, INS=4.
- Instruction codes:
  - 0 halt, 1 nop, 2 cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq.
- aluA selection:
  - valA for cmov and OPq.
  - valC for irmovq, rmmovq and mrmovq.
  - −8 for call and pushq.
  - +8 for ret and popq.
  - 0 otherwise.
- aluB selection:
  - valB for rmmovq, mrmovq, OPq, call, ret, pushq and popq.
  - 0 otherwise.
- ALU function:
  - `ifun` for OPq: 0 add, 1 sub (B−A), 2 and, 3 xor.
  - add for every other instruction.
  - Unknown OPq ifun yields 0.
- Flags:
  - ZF = result==0.
  - SF = result[W-1].
  - add: OF = (A[W-1]==B[W-1]) && (R[W-1]!=A[W-1]).
  - sub: OF = (A[W-1]!=B[W-1]) && (R[W-1]!=B[W-1]).
  - and/xor: OF=0.
  - All arithmetic wraps mod 2^W.
- set_cc = E_icode==OPq && m_stat==AOK && W_stat==AOK && E_stat==AOK.
  - When set, cc loads the new flags on the rising edge that retires the instruction from E.
- Condition (ifun, evaluated on the current cc):
  - 0 always, 1 le (SF^OF | ZF), 2 l (SF^OF), 3 e (ZF).
  - 4 ne (!ZF), 5 ge (!(SF^OF)), 6 g (!(SF^OF) & !ZF).
  - Other ifun values give 0.
  - e_Cnd is meaningful for icode 2 and 7; it is 0 for all other icodes.
- `e_dstE` = RNONE when E_icode==2 && !e_Cnd; otherwise E_dstE.
- M captures: E_stat, E_icode, e_Cnd, e_Value_E, E_valA, e_dstE, E_dstM.

## Timing
- Reset (async assert, sync-to-clk deassert by top level):
  - E and M registers are loaded with a bubble: stat AOK, icode nop (1), ifun 0, all values 0, all dsts RNONE, M_Cnd 0.
  - cc = {1,0,0}.
- Priority per register: reset > bubble > normal load. E has no stall; it loads every cycle.
- Latency:
  - E→M is one cycle.
  - `e_*` outputs are valid combinationally in the same cycle the instruction occupies E.
- A CC-setting OPq followed immediately by a jXX or cmov:
  - The dependent instruction sees the updated cc one cycle later, with no stall.
- A bubble in E never updates cc, because icode nop is not OPq.
- `E_bubble` and `M_bubble` both asserted: both registers take bubbles on the same edge.
- `rst_n` asserted mid-operation: all state is cleared immediately, regardless of clk.

## Structure
- Shared package `y86_pkg`:
  - icode constants, stat constants, RNONE.
  - ALU function codes and condition-code ifun constants.
- One sub-module: `y86_alu`, purely combinational.
  - Inputs A, B, fun.
  - Outputs result, zf, sf, of.
- Pipeline registers, cc and condition logic stay in `execute_stage`.

## Test plan
- Reset: pulse `rst_n` low between clock edges → immediately M_icode=1, M_dstE=M_dstM=15, M_stat=1, cc=3'b100.
- OPq sub, valA=5, valB=3, dstE=2:
  - e_Value_E=−2 and e_dstE=2 in the same cycle.
  - After the edge: M_Value_E=−2, cc={0,1,0}.
- After the sub:
  - cmovle (ifun 1), rB=3 → e_Cnd=1, e_dstE=3.
  - cmovg (ifun 6) → e_Cnd=0, e_dstE=15, and M_dstE=15 after the edge.
- add 0x7FFF_FFFF_FFFF_FFFF + 1 → e_Value_E=0x8000_0000_0000_0000, cc={0,1,1}. jl then gives e_Cnd=0 and jle gives e_Cnd=0.
- Stack ops, valB=256:
  - pushq → e_Value_E=248.
  - popq → 264.
  - call → 248, with M_Value_A equal to the valA input.
- Suppression:
  - OPq xor 5^5 with m_stat=ADR → cc unchanged.
  - Same instruction with E_bubble=1 on its load edge → M_icode=1 next cycle and cc unchanged.
